store_narrow_unit: RTL

//  Store-path counterpart of the immediate/load extender: narrows a 32-bit register value to

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/store_lane_format.sv | 57 +++++
 rtl/store_narrow_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//  Shared definitions for the data-memory store path: access size encodings,
//  the store FSM state type, byte-enable constants and a word-address helper.
//  Imported by store_lane_format and store_narrow_unit.
//  No ports (package).
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  // Access size as carried on st_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Store FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_REQ   = 2'b10
  } state_e;

  // Byte-enable patterns, bit i = little-endian byte lane i
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Memory is word organised; lane selection is carried by the byte enables
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_format.sv
// ---------------------------------------------------------------------------
// store_lane_format
//  Purely combinational lane formatter for stores. Replicates the narrowed
//  register value across all lanes so the memory only has to honour the byte
//  enables, and derives the byte enables from size and low address bits.
//  Optional feature macro: MISALIGN_TRAP_EN
//    defined   : misaligned half/word and the illegal size raise o_err
//    undefined : o_err is always 0, low address bits below the access size
//                are ignored and the illegal size behaves as a word
//  Ports:
//    i_size    [1:0]  access size (mips_mem_pkg::size_e encoding)
//    i_addr_lo [1:0]  byte offset within the word
//    i_data    [31:0] register value, low bits used for byte/half
//    o_wdata   [31:0] lane-replicated write data
//    o_be      [3:0]  byte enables
//    o_err            request must be dropped (trap build only)
// ---------------------------------------------------------------------------
module store_lane_format
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_err
);

  // Word formatting is the default so the illegal size falls through to it
  // when trapping is disabled.
  always_comb begin
    o_wdata = i_data;
    o_be    = BE_WORD;
    o_err   = 1'b0;
    case (size_e'(i_size))
      SZ_BYTE: begin
        o_wdata = {4{i_data[7:0]}};
        o_be    = BE_BYTE0 << i_addr_lo;
      end
      SZ_HALF: begin
        o_wdata = {2{i_data[15:0]}};
        o_be    = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
`ifdef MISALIGN_TRAP_EN
        o_err   = i_addr_lo[0];
`endif
      end
      default: begin
        o_wdata = i_data;
        o_be    = BE_WORD;
`ifdef MISALIGN_TRAP_EN
        o_err   = (size_e'(i_size) == SZ_ILL) || (i_addr_lo != 2'b00);
`endif
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// ---------------------------------------------------------------------------
// store_narrow_unit
//  Store path between the EX/MEM stage and data memory. Accepts one store
//  request at a time, formats it onto the byte lanes, and runs a req/ack
//  write to memory with an optional timeout. The pipeline is held off via
//  o_st_ready until the write completes or is dropped.
//  Optional feature macro: MISALIGN_TRAP_EN (see store_lane_format)
//  Parameters:
//    TIMEOUT  REQ cycles to wait for ack before bus error, 0 = forever
//    CNT_W    timeout counter width
//  Ports:
//    i_clk, i_rst_n        clock, synchronous active-low reset
//    i_st_valid/o_st_ready store request handshake
//    i_st_size [1:0]       access size
//    i_st_addr [31:0]      byte address
//    i_st_data [31:0]      register value
//    o_mem_req             write request, held until ack
//    o_mem_addr [31:0]     word address
//    o_mem_wdata [31:0]    lane-replicated write data
//    o_mem_be [3:0]        byte enables
//    i_mem_ack             memory accepted the write
//    o_done                one-cycle pulse, write completed
//    o_misalign            one-cycle pulse, request dropped as misaligned
//    o_bus_err             one-cycle pulse, write abandoned on timeout
// ---------------------------------------------------------------------------
module store_narrow_unit
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  output logic        o_done,
  output logic        o_misalign,
  output logic        o_bus_err
);

  // Count value seen on the last REQ cycle before giving up
  localparam logic [CNT_W-1:0] LP_CNT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e      r_state;
  state_e      w_next_state;

  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done;
  logic        r_misalign;
  logic        r_bus_err;

  logic [31:0] w_fmt_wdata;
  logic [3:0]  w_fmt_be;
  logic        w_fmt_err;

  logic        w_accept;
  logic        w_timeout;
  logic        w_issue;
  logic        w_finish;
  logic        w_done_nxt;
  logic        w_misalign_nxt;
  logic        w_bus_err_nxt;

  // Formatting works on the registered request during CHECK so the input
  // bus only has to be valid at the accept edge.
  store_lane_format u_fmt (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_data    (r_data),
    .o_wdata   (w_fmt_wdata),
    .o_be      (w_fmt_be),
    .o_err     (w_fmt_err)
  );

  assign w_accept  = i_st_valid & o_st_ready;
  // With TIMEOUT of 0 the counter still runs but is never compared
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        w_next_state = w_fmt_err ? ST_IDLE : ST_REQ;
      end
      ST_REQ: begin
        if (i_mem_ack || w_timeout) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output / control decode. Ack takes priority over the timeout so an ack
  // on the final cycle still completes the write, and the three status
  // pulses come from disjoint state/condition terms so they never overlap.
  always_comb begin
    o_st_ready     = 1'b0;
    w_issue        = 1'b0;
    w_finish       = 1'b0;
    w_done_nxt     = 1'b0;
    w_misalign_nxt = 1'b0;
    w_bus_err_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_st_ready = i_rst_n;
      end
      ST_CHECK: begin
        w_issue        = ~w_fmt_err;
        w_misalign_nxt = w_fmt_err;
      end
      ST_REQ: begin
        w_finish      = i_mem_ack | w_timeout;
        w_done_nxt    = i_mem_ack;
        w_bus_err_nxt = ~i_mem_ack & w_timeout;
      end
      default: begin
        o_st_ready = 1'b0;
      end
    endcase
  end

  // Request capture, memory interface registers and status pulses. Address
  // and data are left as they were when a write finishes; only the request
  // and the byte enables are dropped so nothing is written afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= BE_NONE;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_done     <= w_done_nxt;
      r_misalign <= w_misalign_nxt;
      r_bus_err  <= w_bus_err_nxt;

      if (w_accept) begin
        r_size <= i_st_size;
        r_addr <= i_st_addr;
        r_data <= i_st_data;
      end

      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= word_addr(r_addr);
        r_mem_wdata <= w_fmt_wdata;
        r_mem_be    <= w_fmt_be;
        r_cnt       <= '0;
      end else if (w_finish) begin
        r_mem_req <= 1'b0;
        r_mem_be  <= BE_NONE;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_done      = r_done;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;

endmodule
